// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the pipelined RV32I core.
// Issues one word fetch at a time to a variable-latency imem over a
// req/gnt/rvalid handshake. Returned words go into a one-entry buffer that
// feeds the Fetch/Decode register. Execute-stage redirects retarget fetch and
// discard any response that is still in flight.
// Optional build macro FETCH_PERF_CNT_EN adds o_fetch_wait_cnt, a saturating
// count of cycles spent waiting on the memory.

`ifndef XLEN
`define XLEN 32
`endif

module fetch_ctrl #(
   parameter logic [`XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_redirect,
   input  logic [`XLEN-1:0]  i_redirect_pc,
   input  logic              i_StallD,
   output logic              o_imem_req,
   output logic [`XLEN-1:0]  o_imem_addr,
   input  logic              i_imem_gnt,
   input  logic              i_imem_rvalid,
   input  logic [`XLEN-1:0]  i_imem_rdata,
   output logic [`XLEN-1:0]  o_instrF,
   output logic [`XLEN-1:0]  o_PCF,
   output logic [`XLEN-1:0]  o_PCPlus4F,
   output logic              o_StallD_en,
   output logic              o_FlushD_CLR
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       o_fetch_wait_cnt
`endif
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] REQ     = 2'd1;
   localparam logic [1:0] WAIT    = 2'd2;
   localparam logic [1:0] DISCARD = 2'd3;

   logic [1:0]        state;
   logic [`XLEN-1:0]  next_pc;
   logic [`XLEN-1:0]  inflight_pc;
   logic              buf_valid;
   logic [`XLEN-1:0]  buf_instr;
   logic [`XLEN-1:0]  buf_pc;

   logic              consume;
   logic              req;
   logic              load;
   logic [`XLEN-1:0]  redirect_target;

   // Handshake and buffer-control terms shared by the state machine and buffer
   always_comb begin
      redirect_target = i_redirect_pc & ~32'd3;
      consume         = buf_valid && !i_StallD;
      req             = (state == REQ) && !i_redirect && (!buf_valid || consume);
      load            = (state == WAIT) && i_imem_rvalid && !i_redirect;
   end

   // Fetch sequencer: tracks the single outstanding request and the next fetch address
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= IDLE;
         next_pc     <= RESET_PC;
         inflight_pc <= '0;
      end else begin
         case (state)
            IDLE: begin
               state <= REQ;
            end
            REQ: begin
               if (i_redirect) begin
                  next_pc <= redirect_target;
               end else if (req && i_imem_gnt) begin
                  inflight_pc <= next_pc;
                  next_pc     <= next_pc + 32'd4;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               if (i_imem_rvalid) begin
                  if (i_redirect) begin
                     next_pc <= redirect_target;
                  end
                  state <= REQ;
               end else if (i_redirect) begin
                  next_pc <= redirect_target;
                  state   <= DISCARD;
               end
            end
            DISCARD: begin
               if (i_redirect) begin
                  next_pc <= redirect_target;
               end
               if (i_imem_rvalid) begin
                  state <= REQ;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // One-entry buffer: redirect empties it, a load beats a same-cycle consume
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         buf_valid <= 1'b0;
         buf_instr <= '0;
         buf_pc    <= '0;
      end else if (i_redirect) begin
         buf_valid <= 1'b0;
      end else if (load) begin
         buf_valid <= 1'b1;
         buf_instr <= i_imem_rdata;
         buf_pc    <= inflight_pc;
      end else if (consume) begin
         buf_valid <= 1'b0;
      end
   end

   // Outputs toward imem and the Fetch/Decode register
   always_comb begin
      o_imem_req   = req;
      o_imem_addr  = next_pc;
      o_instrF     = buf_instr;
      o_PCF        = buf_pc;
      o_PCPlus4F   = buf_pc + 32'd4;
      o_StallD_en  = i_StallD;
      o_FlushD_CLR = i_redirect || (!buf_valid && !i_StallD);
   end

`ifdef FETCH_PERF_CNT_EN
   logic wait_cycle;

   // A wait cycle is one spent on an outstanding response or an ungranted request
   always_comb begin
      wait_cycle = (state == WAIT) || (state == DISCARD) || (req && !i_imem_gnt);
   end

   // Saturating counter of memory wait cycles
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_fetch_wait_cnt <= '0;
      end else if (wait_cycle && (o_fetch_wait_cnt != 32'hFFFF_FFFF)) begin
         o_fetch_wait_cnt <= o_fetch_wait_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl. Each task drives one scenario
// cycle by cycle and compares outputs against hand-computed values.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.

`timescale 1ns/1ps

module tb_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic [31:0] o_instrF;
   logic [31:0] o_PCF;
   logic [31:0] o_PCPlus4F;
   logic        o_StallD_en;
   logic        o_FlushD_CLR;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] o_fetch_wait_cnt;
`endif

   int total;
   int bad;

   fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .i_StallD      (stall),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (gnt),
      .i_imem_rvalid (rvalid),
      .i_imem_rdata  (rdata),
      .o_instrF      (o_instrF),
      .o_PCF         (o_PCF),
      .o_PCPlus4F    (o_PCPlus4F),
      .o_StallD_en   (o_StallD_en),
      .o_FlushD_CLR  (o_FlushD_CLR)
`ifdef FETCH_PERF_CNT_EN
      ,
      .o_fetch_wait_cnt (o_fetch_wait_cnt)
`endif
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic [31:0] t, input logic s,
                        input logic g, input logic v, input logic [31:0] d);
      redirect    = r;
      redirect_pc = t;
      stall       = s;
      gnt         = g;
      rvalid      = v;
      rdata       = d;
      #1;
   endtask

   // Holds reset for two edges and releases it, leaving the DUT in its IDLE cycle
   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      total++; if (o_imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=%b", o_imem_req, 1'b0); end
      total++; if (o_imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=%h", o_imem_addr, 32'h0); end
      total++; if (o_instrF !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=%h", o_instrF, 32'h0); end
      total++; if (o_PCF !== 32'h0) begin bad++; $display("FAIL rst_pcf got=%h want=%h", o_PCF, 32'h0); end
      total++; if (o_PCPlus4F !== 32'h4) begin bad++; $display("FAIL rst_pc4 got=%h want=%h", o_PCPlus4F, 32'h4); end
      total++; if (o_StallD_en !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=%b", o_StallD_en, 1'b0); end
      total++; if (o_FlushD_CLR !== 1'b1) begin bad++; $display("FAIL rst_flush got=%b want=%b", o_FlushD_CLR, 1'b1); end
      rst = 1'b0;
      #1;
      total++; if (o_imem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%b want=%b", o_imem_req, 1'b0); end
      tick();
   endtask

   // gnt always 1, rvalid the cycle after gnt, word at address A is A
   task automatic test_stream();
      logic        due;
      logic [31:0] due_addr;
      logic        exp_req;
      logic        exp_flush;
      logic [31:0] exp_pc;
      due = 1'b0;
      due_addr = 32'h0;
      do_reset();
      tick();
      for (int k = 0; k < 9; k++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b1, due, due_addr);
         exp_req   = (k % 2 == 0);
         exp_flush = !((k >= 2) && (k % 2 == 0));
         total++; if (o_imem_req !== exp_req) begin bad++; $display("FAIL stream_req k=%0d got=%b want=%b", k, o_imem_req, exp_req); end
         total++; if (o_FlushD_CLR !== exp_flush) begin bad++; $display("FAIL stream_flush k=%0d got=%b want=%b", k, o_FlushD_CLR, exp_flush); end
         if (k % 2 == 0) begin
            total++; if (o_imem_addr !== 32'(k * 2)) begin bad++; $display("FAIL stream_addr k=%0d got=%h want=%h", k, o_imem_addr, 32'(k * 2)); end
         end
         if ((k >= 2) && (k % 2 == 0)) begin
            exp_pc = 32'((k / 2 - 1) * 4);
            total++; if (o_PCF !== exp_pc) begin bad++; $display("FAIL stream_pcf k=%0d got=%h want=%h", k, o_PCF, exp_pc); end
            total++; if (o_instrF !== exp_pc) begin bad++; $display("FAIL stream_instr k=%0d got=%h want=%h", k, o_instrF, exp_pc); end
            total++; if (o_PCPlus4F !== exp_pc + 32'd4) begin bad++; $display("FAIL stream_pc4 k=%0d got=%h want=%h", k, o_PCPlus4F, exp_pc + 32'd4); end
         end
         due      = o_imem_req & gnt;
         due_addr = o_imem_addr;
         tick();
      end
   endtask

   task automatic test_gnt_delay();
      do_reset();
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h4); tick();
      for (int k = 4; k < 8; k++) begin
         drive(1'b0, 32'h0, 1'b0, (k == 7), 1'b0, 32'h0);
         total++; if (o_imem_req !== 1'b1) begin bad++; $display("FAIL gdly_req k=%0d got=%b want=%b", k, o_imem_req, 1'b1); end
         total++; if (o_imem_addr !== 32'h8) begin bad++; $display("FAIL gdly_addr k=%0d got=%h want=%h", k, o_imem_addr, 32'h8); end
         if (k > 4) begin
            total++; if (o_FlushD_CLR !== 1'b1) begin bad++; $display("FAIL gdly_flush k=%0d got=%b want=%b", k, o_FlushD_CLR, 1'b1); end
         end
         tick();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8);
      total++; if (o_imem_req !== 1'b0) begin bad++; $display("FAIL gdly_wait_req got=%b want=%b", o_imem_req, 1'b0); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      total++; if (o_PCF !== 32'h8) begin bad++; $display("FAIL gdly_pcf got=%h want=%h", o_PCF, 32'h8); end
      total++; if (o_instrF !== 32'h8) begin bad++; $display("FAIL gdly_instr got=%h want=%h", o_instrF, 32'h8); end
      total++; if (o_FlushD_CLR !== 1'b0) begin bad++; $display("FAIL gdly_noflush got=%b want=%b", o_FlushD_CLR, 1'b0); end
      tick();
   endtask

   task automatic test_redirect_wait();
      do_reset();
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0); tick();
      drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
      total++; if (o_FlushD_CLR !== 1'b1) begin bad++; $display("FAIL rdw_flush got=%b want=%b", o_FlushD_CLR, 1'b1); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      total++; if (o_imem_req !== 1'b0) begin bad++; $display("FAIL rdw_disc_req got=%b want=%b", o_imem_req, 1'b0); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hBAD0_BAD0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      total++; if (o_imem_req !== 1'b1) begin bad++; $display("FAIL rdw_req got=%b want=%b", o_imem_req, 1'b1); end
      total++; if (o_imem_addr !== 32'h100) begin bad++; $display("FAIL rdw_addr got=%h want=%h", o_imem_addr, 32'h100); end
      total++; if (o_instrF !== 32'h0) begin bad++; $display("FAIL rdw_stale got=%h want=%h", o_instrF, 32'h0); end
      total++; if (o_FlushD_CLR !== 1'b1) begin bad++; $display("FAIL rdw_empty_flush got=%b want=%b", o_FlushD_CLR, 1'b1); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0013); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      total++; if (o_PCF !== 32'h100) begin bad++; $display("FAIL rdw_pcf got=%h want=%h", o_PCF, 32'h100); end
      total++; if (o_instrF !== 32'h13) begin bad++; $display("FAIL rdw_instr got=%h want=%h", o_instrF, 32'h13); end
      tick();
   endtask

   task automatic test_redirect_rvalid();
      do_reset();
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0); tick();
      drive(1'b1, 32'h203, 1'b0, 1'b0, 1'b1, 32'h55);
      total++; if (o_FlushD_CLR !== 1'b1) begin bad++; $display("FAIL rdr_flush got=%b want=%b", o_FlushD_CLR, 1'b1); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      total++; if (o_imem_req !== 1'b1) begin bad++; $display("FAIL rdr_req got=%b want=%b", o_imem_req, 1'b1); end
      total++; if (o_imem_addr !== 32'h200) begin bad++; $display("FAIL rdr_addr got=%h want=%h", o_imem_addr, 32'h200); end
      total++; if (o_FlushD_CLR !== 1'b1) begin bad++; $display("FAIL rdr_empty got=%b want=%b", o_FlushD_CLR, 1'b1); end
      total++; if (o_instrF !== 32'h0) begin bad++; $display("FAIL rdr_dropped got=%h want=%h", o_instrF, 32'h0); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h77); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      total++; if (o_PCF !== 32'h200) begin bad++; $display("FAIL rdr_pcf got=%h want=%h", o_PCF, 32'h200); end
      total++; if (o_instrF !== 32'h77) begin bad++; $display("FAIL rdr_instr got=%h want=%h", o_instrF, 32'h77); end
      tick();
   endtask

   task automatic test_stall();
      do_reset();
      tick();
      drive(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0);
      total++; if (o_imem_req !== 1'b0) begin bad++; $display("FAIL stl_redir_req got=%b want=%b", o_imem_req, 1'b0); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA10); tick();
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
         total++; if (o_imem_req !== 1'b0) begin bad++; $display("FAIL stl_req k=%0d got=%b want=%b", k, o_imem_req, 1'b0); end
         total++; if (o_StallD_en !== 1'b1) begin bad++; $display("FAIL stl_en k=%0d got=%b want=%b", k, o_StallD_en, 1'b1); end
         total++; if (o_FlushD_CLR !== 1'b0) begin bad++; $display("FAIL stl_flush k=%0d got=%b want=%b", k, o_FlushD_CLR, 1'b0); end
         total++; if (o_PCF !== 32'h10) begin bad++; $display("FAIL stl_pcf k=%0d got=%h want=%h", k, o_PCF, 32'h10); end
         tick();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      total++; if (o_imem_req !== 1'b1) begin bad++; $display("FAIL stl_rel_req got=%b want=%b", o_imem_req, 1'b1); end
      total++; if (o_imem_addr !== 32'h14) begin bad++; $display("FAIL stl_rel_addr got=%h want=%h", o_imem_addr, 32'h14); end
      total++; if (o_StallD_en !== 1'b0) begin bad++; $display("FAIL stl_rel_en got=%b want=%b", o_StallD_en, 1'b0); end
      total++; if (o_instrF !== 32'hA10) begin bad++; $display("FAIL stl_rel_instr got=%h want=%h", o_instrF, 32'hA10); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA14);
      total++; if (o_FlushD_CLR !== 1'b1) begin bad++; $display("FAIL stl_bubble got=%b want=%b", o_FlushD_CLR, 1'b1); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      total++; if (o_PCF !== 32'h14) begin bad++; $display("FAIL stl_next_pcf got=%h want=%h", o_PCF, 32'h14); end
      total++; if (o_instrF !== 32'hA14) begin bad++; $display("FAIL stl_next_instr got=%h want=%h", o_instrF, 32'hA14); end
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      tick();
      drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      total++; if (o_imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h want=%h", o_imem_addr, 32'hFFFF_FFFC); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      total++; if (o_PCF !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pcf got=%h want=%h", o_PCF, 32'hFFFF_FFFC); end
      total++; if (o_PCPlus4F !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h want=%h", o_PCPlus4F, 32'h0); end
      total++; if (o_imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%h want=%h", o_imem_addr, 32'h0); end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h11); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      total++; if (o_instrF !== 32'h11) begin bad++; $display("FAIL rmid_pre_instr got=%h want=%h", o_instrF, 32'h11); end
      tick();
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      total++; if (o_imem_req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b want=%b", o_imem_req, 1'b0); end
      total++; if (o_imem_addr !== 32'h0) begin bad++; $display("FAIL rmid_addr got=%h want=%h", o_imem_addr, 32'h0); end
      total++; if (o_instrF !== 32'h0) begin bad++; $display("FAIL rmid_instr got=%h want=%h", o_instrF, 32'h0); end
      total++; if (o_PCPlus4F !== 32'h4) begin bad++; $display("FAIL rmid_pc4 got=%h want=%h", o_PCPlus4F, 32'h4); end
      total++; if (o_FlushD_CLR !== 1'b1) begin bad++; $display("FAIL rmid_flush got=%b want=%b", o_FlushD_CLR, 1'b1); end
      tick();
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD);
      total++; if (o_imem_req !== 1'b0) begin bad++; $display("FAIL rmid_idle_req got=%b want=%b", o_imem_req, 1'b0); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      total++; if (o_imem_req !== 1'b1) begin bad++; $display("FAIL rmid_first_req got=%b want=%b", o_imem_req, 1'b1); end
      total++; if (o_imem_addr !== 32'h0) begin bad++; $display("FAIL rmid_first_addr got=%h want=%h", o_imem_addr, 32'h0); end
      total++; if (o_instrF !== 32'h0) begin bad++; $display("FAIL rmid_stale got=%h want=%h", o_instrF, 32'h0); end
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h99); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      total++; if (o_PCF !== 32'h0) begin bad++; $display("FAIL rmid_pcf got=%h want=%h", o_PCF, 32'h0); end
      total++; if (o_instrF !== 32'h99) begin bad++; $display("FAIL rmid_word got=%h want=%h", o_instrF, 32'h99); end
      tick();
   endtask

   // Scenario sequence
   initial begin
      total = 0;
      bad   = 0;
      clk   = 1'b0;
      rst   = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      stall       = 1'b0;
      gnt         = 1'b0;
      rvalid      = 1'b0;
      rdata       = 32'h0;
      test_reset();
      test_stream();
      test_gnt_delay();
      test_redirect_wait();
      test_redirect_rvalid();
      test_stall();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
